clk_enable_gen: RTL and testbench

//  Multi-channel programmable clock-enable generator for the paint/VGA fabric.

---
 rtl/clk_enable_gen_if.sv | 23 ++
 rtl/clk_enable_gen.sv | 98 +++++++++
 tb/tb_clk_enable_gen.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/clk_enable_gen_if.sv
// Divisor write, sync and tick/square output bundle for clk_enable_gen.
interface clk_enable_gen_if #(
  parameter int NCH = 4,
  parameter int CW  = 24
);
  logic           wr_en;
  logic [7:0]     wr_ch;
  logic [CW-1:0]  wr_div;
  logic           sync;
  logic [NCH-1:0] tick;
  logic [NCH-1:0] sq;
  logic [NCH-1:0] upd_pend;

  modport master (
    output wr_en, wr_ch, wr_div, sync,
    input  tick, sq, upd_pend
  );

  modport slave (
    input  wr_en, wr_ch, wr_div, sync,
    output tick, sq, upd_pend
  );
endinterface

// File: rtl/clk_enable_gen.sv
// Multi-channel programmable clock-enable generator: registered tick strobes and 50% squares.
// Optional CLKDIV_SYNC_EN builds a global phase-align strobe; otherwise sync is ignored.
module clk_enable_gen #(
  parameter int NCH         = 4,
  parameter int CW          = 24,
  parameter int DIV_DEFAULT = 4
) (
  input  logic             clk,
  input  logic             clr,
  clk_enable_gen_if.slave  bus
);

  localparam logic [CW-1:0] DIV_RST = CW'(DIV_DEFAULT);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0]  cnt_q      [NCH];
  logic [CW-1:0]  cnt_d      [NCH];
  logic [CW-1:0]  div_q      [NCH];
  logic [CW-1:0]  div_d      [NCH];
  logic [CW-1:0]  pend_div_q [NCH];
  logic [CW-1:0]  pend_div_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] tick_q, tick_d;
  logic [NCH-1:0] sq_q, sq_d;
  logic           sync_hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_hit = bus.sync;
`else
  logic unused_sync;
  assign sync_hit    = 1'b0;
  assign unused_sync = bus.sync;
`endif

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      cnt_d[i]      = cnt_q[i];
      div_d[i]      = div_q[i];
      pend_div_d[i] = pend_div_q[i];
      pend_d[i]     = pend_q[i];
      tick_d[i]     = 1'b0;
      sq_d[i]       = sq_q[i];

      // Pending divisors only land at a period boundary, so no runt periods.
      if (sync_hit || div_q[i] == '0) begin
        cnt_d[i] = '0;
        sq_d[i]  = 1'b0;
        if (pend_q[i]) begin
          div_d[i]  = pend_div_q[i];
          pend_d[i] = 1'b0;
        end
      end else if (cnt_q[i] == div_q[i] - ONE) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
        if (pend_q[i]) begin
          div_d[i]  = pend_div_q[i];
          pend_d[i] = 1'b0;
        end
      end else begin
        cnt_d[i] = cnt_q[i] + ONE;
      end

      // A write on an apply edge stays pending for the next boundary.
      if (bus.wr_en && int'(bus.wr_ch) == i) begin
        pend_div_d[i] = bus.wr_div;
        pend_d[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= '0;
        div_q[i]      <= DIV_RST;
        pend_div_q[i] <= '0;
      end
      pend_q <= '0;
      tick_q <= '0;
      sq_q   <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        cnt_q[i]      <= cnt_d[i];
        div_q[i]      <= div_d[i];
        pend_div_q[i] <= pend_div_d[i];
      end
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.sq       = sq_q;
  assign bus.upd_pend = pend_q;

endmodule

// File: tb/tb_clk_enable_gen.sv
// Directed bench for clk_enable_gen; edge numbers count rising edges after reset release.
module tb_clk_enable_gen;

  logic clk;
  logic clr;
  int   edge_n;
  int   checks;
  int   errors;

  clk_enable_gen_if #(.NCH(4), .CW(24)) bus ();

  clk_enable_gen #(.NCH(4), .CW(24), .DIV_DEFAULT(4)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at edge %0d: observed=%0h expected=%0h", tag, edge_n, obs, exp);
    end
  endtask

  // Advance to edge n, sampling 1 time unit after it; one-shot strobes drop after the first edge.
  task automatic step_to(input int n);
    while (edge_n < n) begin
      @(posedge clk);
      #1;
      edge_n++;
      bus.wr_en = 1'b0;
      bus.sync  = 1'b0;
    end
  endtask

  task automatic wr(input int ch, input int d);
    bus.wr_en  = 1'b1;
    bus.wr_ch  = 8'(ch);
    bus.wr_div = 24'(d);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    edge_n = -2;
    clr        = 1'b1;
    bus.wr_en  = 1'b0;
    bus.wr_ch  = '0;
    bus.wr_div = '0;
    bus.sync   = 1'b0;

    step_to(0);
    chk("rst_tick", bus.tick, 4'h0);
    chk("rst_sq", bus.sq, 4'h0);
    chk("rst_pend", bus.upd_pend, 4'h0);
    clr = 1'b0;

    // Default divisor 4: ticks on edges 4, 8, 12
    step_to(3);
    chk("pre_first_tick", bus.tick, 4'h0);
    step_to(4);
    chk("tick_e4", bus.tick, 4'hF);
    chk("sq_e4", bus.sq, 4'hF);
    step_to(5);
    chk("tick_e5", bus.tick, 4'h0);
    step_to(8);
    chk("tick_e8", bus.tick, 4'hF);
    chk("sq_e8", bus.sq, 4'h0);
    step_to(12);
    chk("tick_e12", bus.tick, 4'hF);
    chk("sq_e12", bus.sq, 4'hF);

    // ch1 -> div 1, applied on edge 16
    wr(1, 1);
    step_to(13);
    chk("pend_ch1", bus.upd_pend, 4'b0010);
    step_to(16);
    chk("tick_e16", bus.tick, 4'hF);
    chk("pend_clr_ch1", bus.upd_pend, 4'h0);
    step_to(17);
    chk("div1_tick_e17", bus.tick, 4'b0010);
    chk("div1_sq_e17", bus.sq, 4'b0010);
    // ch0 at cnt=1 -> div 10, current period still ends on edge 20
    wr(0, 10);
    step_to(18);
    chk("div1_tick_e18", bus.tick, 4'b0010);
    chk("div1_sq_e18", bus.sq, 4'b0000);
    chk("pend_ch0_e18", bus.upd_pend, 4'b0001);
    step_to(19);
    chk("pend_ch0_e19", bus.upd_pend, 4'b0001);
    chk("ch0_tick_e19", bus.tick[0], 1'b0);
    step_to(20);
    chk("ch0_tick_e20", bus.tick[0], 1'b1);
    chk("pend_ch0_e20", bus.upd_pend, 4'b0000);

    // ch2 -> div 0, stops after its edge-24 terminal count
    wr(2, 0);
    step_to(21);
    chk("pend_ch2", bus.upd_pend, 4'b0100);
    step_to(24);
    chk("ch2_tick_e24", bus.tick[2], 1'b1);
    chk("pend_ch2_e24", bus.upd_pend, 4'b0000);
    step_to(26);
    chk("ch2_stop_tick", bus.tick[2], 1'b0);
    chk("ch2_stop_sq", bus.sq[2], 1'b0);
    step_to(28);
    chk("ch2_stop_tick_e28", bus.tick[2], 1'b0);
    chk("ch3_tick_e28", bus.tick[3], 1'b1);

    // Stopped ch2 -> div 3, applied on the edge after the write lands
    wr(2, 3);
    step_to(29);
    chk("pend_ch2_e29", bus.upd_pend, 4'b0100);
    chk("ch0_tick_e29", bus.tick[0], 1'b0);
    step_to(30);
    chk("ch0_div10_e30", bus.tick[0], 1'b1);
    chk("pend_ch2_e30", bus.upd_pend, 4'b0000);
    step_to(32);
    chk("ch2_tick_e32", bus.tick[2], 1'b0);
    step_to(33);
    chk("ch2_tick_e33", bus.tick[2], 1'b1);
    chk("ch2_sq_e33", bus.sq[2], 1'b1);
    step_to(36);
    chk("ch2_tick_e36", bus.tick[2], 1'b1);
    chk("ch2_sq_e36", bus.sq[2], 1'b0);

    // Out-of-range channel write has no effect
    wr(7, 2);
    step_to(37);
    chk("badch_pend", bus.upd_pend, 4'h0);
    chk("badch_tick_e37", bus.tick, 4'b0010);
    step_to(39);
    chk("tick_e39", bus.tick, 4'b0110);
    step_to(40);
    chk("tick_e40", bus.tick, 4'b1011);

    // Pending write then clr mid-period
    wr(3, 9);
    step_to(41);
    chk("pend_ch3", bus.upd_pend, 4'b1000);
    clr = 1'b1;
    #2;
    chk("clr_tick", bus.tick, 4'h0);
    chk("clr_sq", bus.sq, 4'h0);
    chk("clr_pend", bus.upd_pend, 4'h0);
    step_to(43);
    clr = 1'b0;
    step_to(46);
    chk("post_clr_e46", bus.tick, 4'h0);
    step_to(47);
    chk("post_clr_e47", bus.tick, 4'hF);
    step_to(51);
    chk("post_clr_e51", bus.tick, 4'hF);
    chk("post_clr_pend", bus.upd_pend, 4'h0);

`ifdef CLKDIV_SYNC_EN
    wr(1, 6);
    step_to(57);
    bus.sync = 1'b1;
    step_to(58);
    chk("sync_tick", bus.tick[1:0], 2'b00);
    chk("sync_sq", bus.sq[1:0], 2'b00);
    step_to(62);
    chk("sync_ch0_e62", bus.tick[1:0], 2'b01);
    step_to(64);
    chk("sync_ch1_e64", bus.tick[1:0], 2'b10);
    step_to(70);
    chk("sync_align_e70", bus.tick[1:0], 2'b11);
    chk("sync_sq_e70", bus.sq[1:0], 2'b01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
